// File: rtl/counter_pkg.sv
// counter_pkg: shared counter defaults and direction/mode encodings
package counter_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_DIV = 50_000_000;
  localparam int DEF_DIV_W = 26;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT = 1'b1;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler; tick is the combinational step strobe (en and pre at DIV-1)
module tick_gen #(
  parameter int DIV = 50_000_000,
  parameter int DIV_W = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  logic [DIV_W-1:0] pre;
  assign tick = en && (pre == DIV_W'(DIV - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) pre <= '0;
    else if (clr || tick) pre <= '0;
    else if (en) pre <= pre + DIV_W'(1);
endmodule

// File: rtl/prescaled_updown_counter.sv
// prescaled_updown_counter: up/down wrap/saturate counter stepped by a prescaler tick
module prescaled_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV = DEF_DIV,
  parameter int DIV_W = DEF_DIV_W,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt_out,
  output logic             tick,
  output logic             tc
);
  localparam logic [WIDTH-1:0] MAX = '1;
  logic step, at_term;
  logic [WIDTH-1:0] nxt;
  tick_gen #(.DIV(DIV), .DIV_W(DIV_W)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (load),
    .tick(step)
  );
  // wrapping falls out of modulo arithmetic; only saturation needs a hold
  always_comb begin
    at_term = (dir == DIR_UP) ? (cnt_out == MAX) : (cnt_out == '0);
    nxt = (at_term && sat == MODE_SAT) ? cnt_out
        : (dir == DIR_UP) ? cnt_out + WIDTH'(1) : cnt_out - WIDTH'(1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_out <= RST_VAL;
      tick <= 1'b0;
      tc <= 1'b0;
    end else if (load) begin
      cnt_out <= load_val;
      tick <= 1'b0;
      tc <= 1'b0;
    end else begin
      tick <= step;
      tc <= step && at_term;
      if (step) cnt_out <= nxt;
    end
endmodule

// File: tb/tb_prescaled_updown_counter.sv
// tb_prescaled_updown_counter: directed vector bench for DIV=4 and DIV=1 counters
module tb_prescaled_updown_counter;
  logic clk = 1'b0, rst = 1'b1;
  logic en = 1'b0, dir = 1'b1, sat = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] cnt_out, cnt1;
  logic tick, tc, tick1, tc1;
  logic en1 = 1'b0, load1 = 1'b0;
  int n_tests = 0, n_fail = 0;

  prescaled_updown_counter #(.WIDTH(4), .DIV(4), .DIV_W(2), .RST_VAL(4'd0)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .sat(sat), .load(load),
    .load_val(load_val), .cnt_out(cnt_out), .tick(tick), .tc(tc)
  );
  prescaled_updown_counter #(.WIDTH(4), .DIV(1), .DIV_W(1), .RST_VAL(4'd10)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .dir(dir), .sat(sat), .load(load1),
    .load_val(load_val), .cnt_out(cnt1), .tick(tick1), .tc(tc1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] n;
    logic ld;
    logic [3:0] lv;
    logic en, dir, sat;
    logic [3:0] cnt;
    logic tk, tc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check3(input string name, input int c, input int t, input int p);
    check({name, " cnt"}, int'(cnt_out), c);
    check({name, " tick"}, int'(tick), t);
    check({name, " tc"}, int'(tc), p);
  endtask

  task automatic edge_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // n, load, load_val, en, dir, sat, exp cnt, exp tick, exp tc
    vecs.push_back('{1, 1, 14, 1, 1, 1, 14, 0, 0});
    vecs.push_back('{3, 0, 0, 1, 1, 1, 14, 0, 0});
    vecs.push_back('{1, 0, 0, 1, 1, 1, 15, 1, 0});
    vecs.push_back('{3, 0, 0, 1, 1, 1, 15, 0, 0});
    vecs.push_back('{1, 0, 0, 1, 1, 1, 15, 1, 1});
    vecs.push_back('{3, 0, 0, 1, 1, 1, 15, 0, 0});
    vecs.push_back('{1, 0, 0, 1, 1, 1, 15, 1, 1});
    vecs.push_back('{1, 1, 1, 1, 0, 0, 1, 0, 0});
    vecs.push_back('{3, 0, 0, 1, 0, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 0, 1, 0, 0, 0, 1, 0});
    vecs.push_back('{3, 0, 0, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 1, 0, 0, 15, 1, 1});
    vecs.push_back('{3, 0, 0, 1, 0, 0, 15, 0, 0});
    vecs.push_back('{1, 0, 0, 1, 0, 0, 14, 1, 0});
    vecs.push_back('{2, 0, 0, 1, 0, 0, 14, 0, 0});
    vecs.push_back('{10, 0, 0, 0, 0, 0, 14, 0, 0});
    vecs.push_back('{1, 0, 0, 1, 0, 0, 14, 0, 0});
    vecs.push_back('{1, 0, 0, 1, 0, 0, 13, 1, 0});
    vecs.push_back('{3, 0, 0, 1, 1, 0, 13, 0, 0});
    vecs.push_back('{1, 1, 9, 1, 1, 0, 9, 0, 0});
    vecs.push_back('{3, 0, 0, 1, 1, 0, 9, 0, 0});
    vecs.push_back('{1, 0, 0, 1, 1, 0, 10, 1, 0});
    vecs.push_back('{1, 1, 15, 1, 1, 0, 15, 0, 0});
    vecs.push_back('{3, 0, 0, 1, 1, 0, 15, 0, 0});
    vecs.push_back('{1, 1, 15, 1, 1, 0, 15, 0, 0});
    vecs.push_back('{3, 0, 0, 1, 1, 0, 15, 0, 0});
    vecs.push_back('{1, 0, 0, 1, 1, 0, 0, 1, 1});
    vecs.push_back('{1, 1, 7, 0, 1, 0, 7, 0, 0});
    vecs.push_back('{5, 0, 0, 0, 1, 0, 7, 0, 0});

    edge_n(2);
    check3("reset", 0, 0, 0);
    check("reset dut1 cnt", int'(cnt1), 10);
    rst = 1'b0;
    en = 1'b1;
    dir = 1'b1;
    sat = 1'b0;
    // free-running up/wrap: step on every 4th edge, wrap on the 64th
    for (int k = 1; k <= 64; k++) begin
      edge_n(1);
      check3($sformatf("up k=%0d", k), (k / 4) % 16, (k % 4 == 0) ? 1 : 0, (k == 64) ? 1 : 0);
    end
    edge_n(22);
    check3("pre-reset", 5, 0, 0);
    rst = 1'b1;
    #1;
    check3("async reset", 0, 0, 0);
    check("async reset dut1", int'(cnt1), 10);
    #1 rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      edge_n(1);
      check3($sformatf("post-reset k=%0d", k), (k == 4) ? 1 : 0, (k == 4) ? 1 : 0, 0);
    end
    foreach (vecs[i]) begin
      load = vecs[i].ld;
      load_val = vecs[i].lv;
      en = vecs[i].en;
      dir = vecs[i].dir;
      sat = vecs[i].sat;
      edge_n(int'(vecs[i].n));
      check3($sformatf("vec %0d", i), int'(vecs[i].cnt), int'(vecs[i].tk), int'(vecs[i].tc));
    end
    load = 1'b0;
    en = 1'b0;
    check("div1 frozen", int'(cnt1), 10);
    load1 = 1'b1;
    load_val = 4'd3;
    dir = 1'b1;
    sat = 1'b0;
    edge_n(1);
    check("div1 load cnt", int'(cnt1), 3);
    check("div1 load tick", int'(tick1), 0);
    load1 = 1'b0;
    en1 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      edge_n(1);
      check($sformatf("div1 step %0d cnt", i), int'(cnt1), 3 + i);
      check($sformatf("div1 step %0d tick", i), int'(tick1), 1);
      check($sformatf("div1 step %0d tc", i), int'(tc1), 0);
    end
    load1 = 1'b1;
    load_val = 4'd14;
    edge_n(1);
    check("div1 load14", int'(cnt1), 14);
    load1 = 1'b0;
    edge_n(1);
    check("div1 to15 cnt", int'(cnt1), 15);
    check("div1 to15 tc", int'(tc1), 0);
    edge_n(1);
    check("div1 wrap cnt", int'(cnt1), 0);
    check("div1 wrap tc", int'(tc1), 1);
    en1 = 1'b0;
    edge_n(1);
    check("div1 idle tick", int'(tick1), 0);
    check("div1 idle cnt", int'(cnt1), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
